switch_out_arbiter: RTL and testbench

//   Output-port scheduler for one switch output: shares one output link among PORTS_NUM+1 input queues
//   (PORTS_NUM topology ports plus the local IP port).

---
 rtl/switch_out_arbiter_pkg.sv | 37 +++
 rtl/switch_out_arbiter_rr_picker.sv | 42 ++++
 rtl/switch_out_arbiter.sv | 139 +++++++++++++
 tb/tb_switch_out_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_out_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// switch_out_arbiter_pkg
//   Shared types and helpers for the switch output-port scheduler.
//   - arb_state_e : wormhole arbiter FSM states
//   - flit layout : flit = {last, addr, data}; field offsets derived from
//                   DATA_SIZE / ADDR_SIZE so every user agrees on one layout
//   - rr_idx      : cyclic index helper used by the picker and the pointer
//                   update so both wrap identically
// ---------------------------------------------------------------------------
package switch_out_arbiter_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_e;

   function automatic int unsigned flit_size(int unsigned data_size, int unsigned addr_size);
      return data_size + addr_size + 1;
   endfunction

   function automatic int unsigned last_bit(int unsigned data_size, int unsigned addr_size);
      return data_size + addr_size;
   endfunction

   function automatic int unsigned addr_lsb(int unsigned data_size);
      return data_size;
   endfunction

   // (base + off) wrapped into [0, n); base and off are both expected < n.
   function automatic int unsigned rr_idx(int unsigned base, int unsigned off, int unsigned n);
      int unsigned s;
      s = base + off;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/switch_out_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker: selects the first asserted request at
//   or after ptr_i, wrapping from IN_NUM-1 back to 0.
// Ports:
//   req_i  in  IN_NUM  request vector
//   ptr_i  in  PTR_W   highest-priority index for this pick
//   gnt_o  out IN_NUM  one-hot winner (all zero when no request)
//   any_o  out 1       at least one request asserted
// ---------------------------------------------------------------------------
module rr_picker
   import switch_out_arbiter_pkg::*;
#(
   parameter int unsigned IN_NUM = 5,
   parameter int unsigned PTR_W  = 3
) (
   input  logic [IN_NUM-1:0] req_i,
   input  logic [PTR_W-1:0]  ptr_i,
   output logic [IN_NUM-1:0] gnt_o,
   output logic              any_o
);

   logic        found;
   int unsigned idx;

   // Walking the requests in rotated order is the rotate / priority-encode /
   // rotate-back structure folded into one loop.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < IN_NUM; k++) begin
         idx = rr_idx(32'(ptr_i), k, IN_NUM);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/switch_out_arbiter.sv
// ---------------------------------------------------------------------------
// switch_out_arbiter
//   Output-port scheduler for one switch output. Shares the output link among
//   PORTS_NUM topology inputs plus the local IP input (index PORTS_NUM) using
//   wormhole arbitration: round-robin pick at a packet head, grant locked
//   until the tail flit transfers.
// Ports:
//   clk          in   clock
//   a_rst        in   synchronous active-low reset
//   req_i        in   IN_NUM           input i has a head flit for this output
//   data_i       in   IN_NUM*FLIT_SIZE head flits, input i at [i*FLIT_SIZE +: FLIT_SIZE]
//   pop_o        out  IN_NUM           one-hot, combinational: head flit consumed
//   wr_ready_in  in   downstream can accept a flit this cycle
//   data_o       out  FLIT_SIZE        registered output flit
//   valid_o      out  registered one-cycle write strobe for data_o
//   grant_o      out  IN_NUM           registered one-hot owner, 0 when idle
//   busy_o       out  high while locked to an owner
//   pkt_cnt_o    out  32               tail flits forwarded since reset (wraps)
// ---------------------------------------------------------------------------
module switch_out_arbiter
   import switch_out_arbiter_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned ADDR_SIZE = 4,
   parameter int unsigned PORTS_NUM = 4
) (
   input  logic                                                  clk,
   input  logic                                                  a_rst,
   input  logic [PORTS_NUM:0]                                    req_i,
   input  logic [(PORTS_NUM+1)*flit_size(DATA_SIZE,ADDR_SIZE)-1:0] data_i,
   output logic [PORTS_NUM:0]                                    pop_o,
   input  logic                                                  wr_ready_in,
   output logic [flit_size(DATA_SIZE,ADDR_SIZE)-1:0]             data_o,
   output logic                                                  valid_o,
   output logic [PORTS_NUM:0]                                    grant_o,
   output logic                                                  busy_o,
   output logic [31:0]                                           pkt_cnt_o
);

   localparam int unsigned IN_NUM    = PORTS_NUM + 1;
   localparam int unsigned FLIT_SIZE = flit_size(DATA_SIZE, ADDR_SIZE);
   localparam int unsigned LAST_BIT  = last_bit(DATA_SIZE, ADDR_SIZE);
   localparam int unsigned PTR_W     = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;

   arb_state_e            state_q, state_d;
   logic [IN_NUM-1:0]     grant_q, grant_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [FLIT_SIZE-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic [31:0]           pkt_cnt_q, pkt_cnt_d;

   logic [IN_NUM-1:0]     pick;
   logic                  pick_any;
   logic [FLIT_SIZE-1:0]  owner_flit;
   logic [PTR_W-1:0]      ptr_after_owner;
   logic                  xfer;

   rr_picker #(
      .IN_NUM (IN_NUM),
      .PTR_W  (PTR_W)
   ) u_picker (
      .req_i  (req_i),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (pick),
      .any_o  (pick_any)
   );

   // Owner's head flit and the pointer slot just past the owner, both
   // selected by the one-hot grant so no binary owner index is needed.
   always_comb begin
      owner_flit      = '0;
      ptr_after_owner = '0;
      for (int unsigned i = 0; i < IN_NUM; i++) begin
         if (grant_q[i]) begin
            owner_flit      = owner_flit | data_i[i*FLIT_SIZE +: FLIT_SIZE];
            ptr_after_owner = PTR_W'(rr_idx(i, 1, IN_NUM));
         end
      end
   end

   // grant_q is zero outside LOCKED, so pop stays zero in IDLE and in reset.
   assign xfer  = (state_q == ST_LOCKED) && |(req_i & grant_q) && wr_ready_in && a_rst;
   assign pop_o = grant_q & {IN_NUM{xfer}};

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      pkt_cnt_d = pkt_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (xfer) begin
               data_d  = owner_flit;
               valid_d = 1'b1;
               if (owner_flit[LAST_BIT]) begin
                  state_d   = ST_IDLE;
                  grant_d   = '0;
                  rr_ptr_d  = ptr_after_owner;
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!a_rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign grant_o   = grant_q;
   assign busy_o    = (state_q == ST_LOCKED);
   assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_switch_out_arbiter
//   Directed bench for switch_out_arbiter with PORTS_NUM=4 (5 requesters).
//   A per-cycle vector table covers reset, single packet, pointer advance,
//   lock under contention and back-pressure; hand sequences cover the
//   round-robin rotation, mid-packet reset and counter wrap.
// ---------------------------------------------------------------------------
module tb_switch_out_arbiter;

   localparam int unsigned IN_NUM = 5;
   localparam int unsigned FS     = 37;

   logic                   clk = 1'b0;
   logic                   a_rst;
   logic [IN_NUM-1:0]      req_i;
   logic [IN_NUM*FS-1:0]   data_i;
   logic [IN_NUM-1:0]      pop_o;
   logic                   wr_ready_in;
   logic [FS-1:0]          data_o;
   logic                   valid_o;
   logic [IN_NUM-1:0]      grant_o;
   logic                   busy_o;
   logic [31:0]            pkt_cnt_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   switch_out_arbiter #(
      .DATA_SIZE (32),
      .ADDR_SIZE (4),
      .PORTS_NUM (4)
   ) dut (
      .clk         (clk),
      .a_rst       (a_rst),
      .req_i       (req_i),
      .data_i      (data_i),
      .pop_o       (pop_o),
      .wr_ready_in (wr_ready_in),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .grant_o     (grant_o),
      .busy_o      (busy_o),
      .pkt_cnt_o   (pkt_cnt_o)
   );

   typedef struct {
      logic        rst_n;
      logic [4:0]  req;
      logic [4:0]  last;
      logic        wr;
      logic [4:0]  pop;    // expected pop_o in this cycle
      logic [4:0]  grant;  // expected grant_o after the edge
      logic        valid;  // expected valid_o after the edge
      logic [31:0] cnt;    // expected pkt_cnt_o after the edge
   } vec_t;

   vec_t tv[30];

   function automatic logic [FS-1:0] mk(int unsigned i, int unsigned v, logic last);
      return {last, 4'(i), 32'(v * 256 + i)};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic rst_n, logic [4:0] req, logic [4:0] last, logic wr, int unsigned tag);
      a_rst       = rst_n;
      req_i       = req;
      wr_ready_in = wr;
      for (int i = 0; i < IN_NUM; i++)
         data_i[i*FS +: FS] = mk(i, tag, last[i]);
   endtask

   initial begin
      logic [FS-1:0] exp_data;
      int unsigned   pops[IN_NUM];
      int unsigned   who;

      tv[0]  = '{1'b0, 5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 32'd0};
      tv[1]  = '{1'b0, 5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 32'd0};
      tv[2]  = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00000, 5'b00001, 1'b0, 32'd0};
      tv[3]  = '{1'b1, 5'b00001, 5'b00001, 1'b1, 5'b00001, 5'b00000, 1'b1, 32'd1};
      tv[4]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 32'd0};
      tv[5]  = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00000, 5'b00100, 1'b0, 32'd0};
      tv[6]  = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'd0};
      tv[7]  = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'd0};
      tv[8]  = '{1'b1, 5'b00100, 5'b00100, 1'b1, 5'b00100, 5'b00000, 1'b1, 32'd1};
      tv[9]  = '{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 32'd1};
      tv[10] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b00000, 5'b01000, 1'b0, 32'd1};
      tv[11] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b01000, 5'b00000, 1'b1, 32'd2};
      tv[12] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b00000, 5'b10000, 1'b0, 32'd2};
      tv[13] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b10000, 5'b00000, 1'b1, 32'd3};
      tv[14] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b00000, 5'b00001, 1'b0, 32'd3};
      tv[15] = '{1'b1, 5'b11011, 5'b11111, 1'b1, 5'b00001, 5'b00000, 1'b1, 32'd4};
      tv[16] = '{1'b1, 5'b00011, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 32'd4};
      tv[17] = '{1'b1, 5'b00011, 5'b00000, 1'b1, 5'b00010, 5'b00010, 1'b1, 32'd4};
      tv[18] = '{1'b1, 5'b00011, 5'b00000, 1'b1, 5'b00010, 5'b00010, 1'b1, 32'd4};
      tv[19] = '{1'b1, 5'b00011, 5'b00010, 1'b1, 5'b00010, 5'b00000, 1'b1, 32'd5};
      tv[20] = '{1'b1, 5'b00001, 5'b00001, 1'b1, 5'b00000, 5'b00001, 1'b0, 32'd5};
      tv[21] = '{1'b1, 5'b00001, 5'b00001, 1'b1, 5'b00001, 5'b00000, 1'b1, 32'd6};
      tv[22] = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00000, 5'b00100, 1'b0, 32'd6};
      tv[23] = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'd6};
      tv[24] = '{1'b1, 5'b00100, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b0, 32'd6};
      tv[25] = '{1'b1, 5'b00100, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b0, 32'd6};
      tv[26] = '{1'b1, 5'b00100, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b0, 32'd6};
      tv[27] = '{1'b1, 5'b00100, 5'b00000, 1'b0, 5'b00000, 5'b00100, 1'b0, 32'd6};
      tv[28] = '{1'b1, 5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'd6};
      tv[29] = '{1'b1, 5'b00100, 5'b00100, 1'b1, 5'b00100, 5'b00000, 1'b1, 32'd7};

      drive(1'b0, 5'b00000, 5'b00000, 1'b0, 0);
      exp_data = '0;

      // ---------------- table-driven vectors ----------------
      for (int v = 0; v < 30; v++) begin
         @(negedge clk);
         drive(tv[v].rst_n, tv[v].req, tv[v].last, tv[v].wr, v);
         #1;
         chk($sformatf("pop[v%0d]", v), 64'(pop_o), 64'(tv[v].pop));
         if (!tv[v].rst_n) exp_data = '0;
         for (int i = 0; i < IN_NUM; i++)
            if (tv[v].pop[i]) exp_data = mk(i, v, tv[v].last[i]);
         @(posedge clk);
         #1;
         chk($sformatf("grant[v%0d]", v), 64'(grant_o), 64'(tv[v].grant));
         chk($sformatf("valid[v%0d]", v), 64'(valid_o), 64'(tv[v].valid));
         chk($sformatf("cnt[v%0d]", v),   64'(pkt_cnt_o), 64'(tv[v].cnt));
         chk($sformatf("busy[v%0d]", v),  64'(busy_o), 64'(|tv[v].grant));
         chk($sformatf("data[v%0d]", v),  64'(data_o), 64'(exp_data));
      end

      // ---------------- round-robin rotation ----------------
      @(negedge clk);
      drive(1'b0, 5'b00000, 5'b00000, 1'b1, 100);
      for (int i = 0; i < IN_NUM; i++) pops[i] = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(1'b1, 5'b11111, 5'b11111, 1'b1, 200 + c);
         who = (c / 2) % IN_NUM;
         #1;
         for (int i = 0; i < IN_NUM; i++) if (pop_o[i]) pops[i]++;
         if (c % 2 == 0) begin
            chk($sformatf("rr_pop_arb[c%0d]", c), 64'(pop_o), 64'(0));
            @(posedge clk); #1;
            chk($sformatf("rr_grant[c%0d]", c), 64'(grant_o), 64'(5'b00001 << who));
         end else begin
            chk($sformatf("rr_pop[c%0d]", c), 64'(pop_o), 64'(5'b00001 << who));
            @(posedge clk); #1;
            chk($sformatf("rr_data[c%0d]", c), 64'(data_o), 64'(mk(who, 200 + c, 1'b1)));
            chk($sformatf("rr_idle[c%0d]", c), 64'(grant_o), 64'(0));
         end
      end
      for (int i = 0; i < IN_NUM; i++)
         chk($sformatf("rr_share[%0d]", i), 64'(pops[i]), 64'(2));

      // ---------------- reset mid-packet ----------------
      @(negedge clk);
      drive(1'b0, 5'b00000, 5'b00000, 1'b1, 300);
      @(negedge clk);
      drive(1'b1, 5'b00001, 5'b00000, 1'b1, 301);
      @(posedge clk); #1;
      chk("mr_grant_arb", 64'(grant_o), 64'(5'b00001));
      for (int f = 0; f < 2; f++) begin
         @(negedge clk);
         drive(1'b1, 5'b00001, 5'b00000, 1'b1, 302 + f);
         #1;
         chk($sformatf("mr_pop[%0d]", f), 64'(pop_o), 64'(5'b00001));
      end
      @(negedge clk);
      drive(1'b0, 5'b00001, 5'b00000, 1'b1, 304);
      #1;
      chk("mr_pop_in_reset", 64'(pop_o), 64'(0));
      @(posedge clk); #1;
      chk("mr_grant", 64'(grant_o), 64'(0));
      chk("mr_valid", 64'(valid_o), 64'(0));
      chk("mr_busy",  64'(busy_o), 64'(0));
      chk("mr_cnt",   64'(pkt_cnt_o), 64'(0));

      // ---------------- packet counter wrap ----------------
      @(negedge clk);
      drive(1'b1, 5'b00000, 5'b00000, 1'b1, 400);
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.pkt_cnt_q;
      chk("wrap_preload", 64'(pkt_cnt_o), 64'(32'hFFFF_FFFF));
      @(negedge clk);
      drive(1'b1, 5'b01000, 5'b01000, 1'b1, 401);
      @(posedge clk); #1;
      chk("wrap_grant", 64'(grant_o), 64'(5'b01000));
      @(negedge clk);
      drive(1'b1, 5'b01000, 5'b01000, 1'b1, 402);
      #1;
      chk("wrap_pop", 64'(pop_o), 64'(5'b01000));
      @(posedge clk); #1;
      chk("wrap_cnt",   64'(pkt_cnt_o), 64'(0));
      chk("wrap_data",  64'(data_o), 64'(mk(3, 402, 1'b1)));
      chk("wrap_valid", 64'(valid_o), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
